// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR encryption sequencer.
// Covers the memory map, the length limits, the pad byte and the FSM states.
package lfsr_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned LFSR_W   = 7;

  localparam int unsigned MSG_BASE = 0;
  localparam int unsigned CFG_PRE  = 61;
  localparam int unsigned CFG_TAP  = 62;
  localparam int unsigned CFG_SEED = 63;
  localparam int unsigned OUT_BASE = 64;

  localparam int unsigned MSG_LEN  = 48;
  localparam int unsigned OUT_LEN  = 60;
  localparam int unsigned PRE_MIN  = 7;
  localparam int unsigned PRE_MAX  = 12;

  localparam logic [WIDTH-1:0] PAD_CHAR = 8'h5F;

  typedef enum logic [2:0] {
    IDLE,
    LD_PRE,
    LD_TAP,
    LD_SEED,
    RUN,
    DONE
  } state_t;

  // Preamble length is clamped with an unsigned compare on the full byte
  function automatic logic [WIDTH-1:0] clamp_pre(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    if (v < WIDTH'(PRE_MIN)) r = WIDTH'(PRE_MIN);
    if (v > WIDTH'(PRE_MAX)) r = WIDTH'(PRE_MAX);
    return r;
  endfunction

endpackage

// File: rtl/lfsr_enc_ctrl_if.sv
// Shared data-memory port: combinational read and clocked write.
// The sequencer is the master and the memory is the slave.
interface lfsr_enc_ctrl_if;
  import lfsr_pkg::*;

  logic [WIDTH-1:0] mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_wen;
  logic [WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  modport master (
    output mem_raddr,
    input  mem_rdata,
    output mem_wen,
    output mem_waddr,
    output mem_wdata
  );

  modport slave (
    input  mem_raddr,
    output mem_rdata,
    input  mem_wen,
    input  mem_waddr,
    input  mem_wdata
  );
endinterface

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR with a programmable tap mask.
// Each advance shifts left and feeds in the parity of the tapped bits.
module lfsr7
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] taps,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= {state[LFSR_W-2:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_enc_ctrl.sv
// Encryption-pass sequencer: loads config, then streams a padded, LFSR-masked
// copy of the message into the output region, one byte per cycle.
module lfsr_enc_ctrl
  import lfsr_pkg::*;
(
  input  logic                   clk,
  input  logic                   init,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  lfsr_enc_ctrl_if.master        mem
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pre_q,   pre_d;
  logic [LFSR_W-1:0]  taps_q,  taps_d;
  logic [WIDTH-1:0]   k_q,     k_d;

  logic               lfsr_load;
  logic [LFSR_W-1:0]  lfsr_seed;
  logic               lfsr_adv;
  logic [LFSR_W-1:0]  lfsr_state;

  logic [WIDTH-1:0]   m;
  logic [LFSR_W-1:0]  pt;

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= IDLE;
      pre_q   <= '0;
      taps_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      taps_q  <= taps_d;
      k_q     <= k_d;
    end
  end

  // Next state and memory-port drive; read data is consumed in the same cycle
  always_comb begin
    state_d       = state_q;
    pre_d         = pre_q;
    taps_d        = taps_q;
    k_d           = k_q;
    busy          = 1'b0;
    done          = 1'b0;
    mem.mem_raddr = '0;
    mem.mem_wen   = 1'b0;
    mem.mem_waddr = '0;
    mem.mem_wdata = '0;
    lfsr_load     = 1'b0;
    lfsr_seed     = '0;
    lfsr_adv      = 1'b0;
    pt            = PAD_CHAR[LFSR_W-1:0];
    m             = k_q - pre_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LD_PRE;
      end

      LD_PRE: begin
        busy          = 1'b1;
        mem.mem_raddr = WIDTH'(CFG_PRE);
        pre_d         = clamp_pre(mem.mem_rdata);
        state_d       = LD_TAP;
      end

      LD_TAP: begin
        busy          = 1'b1;
        mem.mem_raddr = WIDTH'(CFG_TAP);
        taps_d        = mem.mem_rdata[LFSR_W-1:0];
        state_d       = LD_SEED;
      end

      LD_SEED: begin
        busy          = 1'b1;
        mem.mem_raddr = WIDTH'(CFG_SEED);
        lfsr_load     = 1'b1;
        // An all-zero seed would lock the LFSR, so substitute 1
        lfsr_seed     = (mem.mem_rdata[LFSR_W-1:0] == '0) ?
                        LFSR_W'(1) : mem.mem_rdata[LFSR_W-1:0];
        k_d           = '0;
        state_d       = RUN;
      end

      RUN: begin
        busy          = 1'b1;
        mem.mem_wen   = 1'b1;
        mem.mem_waddr = WIDTH'(OUT_BASE) + k_q;
        if ((k_q >= pre_q) && (m < WIDTH'(MSG_LEN))) begin
          mem.mem_raddr = WIDTH'(MSG_BASE) + m;
          pt            = mem.mem_rdata[LFSR_W-1:0];
        end else begin
          mem.mem_raddr = WIDTH'(MSG_BASE);
        end
        mem.mem_wdata = {1'b0, pt ^ lfsr_state};
        lfsr_adv      = 1'b1;
        k_d           = k_q + WIDTH'(1);
        if (k_q == WIDTH'(OUT_LEN - 1)) state_d = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Reset clears the LFSR through its load path
    if (init) begin
      lfsr_load = 1'b1;
      lfsr_seed = '0;
    end
  end

  lfsr7 u_lfsr (
    .clk     (clk),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .taps    (taps_q),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

endmodule
